// File: rtl/blinky_sim_top.sv
// Free-running LED blinker: a two-state ON/OFF FSM whose phase lengths are
// derived from the clock frequency and the requested on/off times.
module blinky_sim_top #(
  parameter int unsigned ClockFrequencyHz = 200,
  parameter int unsigned OnTimeMs         = 500,
  parameter int unsigned OffTimeMs        = 500
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic led_o
);

  // Products are formed in 64 bits so large frequencies cannot overflow
  // before the truncating divide; a zero-length phase is clamped to one cycle.
  localparam longint unsigned OnRaw     = (64'(ClockFrequencyHz) * 64'(OnTimeMs)) / 64'd1000;
  localparam longint unsigned OffRaw    = (64'(ClockFrequencyHz) * 64'(OffTimeMs)) / 64'd1000;
  localparam longint unsigned OnCycles  = (OnRaw == 64'd0) ? 64'd1 : OnRaw;
  localparam longint unsigned OffCycles = (OffRaw == 64'd0) ? 64'd1 : OffRaw;
  localparam longint unsigned MaxCycles = (OnCycles > OffCycles) ? OnCycles : OffCycles;
  localparam int              CntW      = $clog2(MaxCycles + 64'd1);

  localparam logic [CntW-1:0] OnLast  = CntW'(OnCycles - 64'd1);
  localparam logic [CntW-1:0] OffLast = CntW'(OffCycles - 64'd1);

  if (ClockFrequencyHz == 0) begin : g_bad_clock
    $error("blinky_sim_top: ClockFrequencyHz must be >= 1");
  end

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } state_t;

  state_t          state;
  logic [CntW-1:0] cnt;

  // led_o is a flop of its own rather than a decode of state, so the pin
  // never sees combinational glitches.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= OFF;
      cnt   <= '0;
      led_o <= 1'b0;
    end else begin
      unique case (state)
        OFF: begin
          if (cnt == OffLast) begin
            cnt   <= '0;
            state <= ON;
            led_o <= 1'b1;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        ON: begin
          if (cnt == OnLast) begin
            cnt   <= '0;
            state <= OFF;
            led_o <= 1'b0;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blinky_sim_top.sv
// Scoreboard bench for blinky_sim_top: three parameterisations share one
// clock/reset; expected LED transitions are queued and matched by a monitor.
`timescale 1us/1ns
module tb_blinky_sim_top;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic led_def, led_asym, led_min;
  logic [2:0] leds;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int   edge_no;
    logic level;
  } ev_t;

  ev_t q_def[$];
  ev_t q_asym[$];
  ev_t q_min[$];

  // 200 Hz clock: 5 ms period.
  always #2500 clk_i = ~clk_i;

  blinky_sim_top u_dut_def (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .led_o (led_def)
  );

  blinky_sim_top #(
    .ClockFrequencyHz (200),
    .OnTimeMs         (50),
    .OffTimeMs        (150)
  ) u_dut_asym (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .led_o (led_asym)
  );

  blinky_sim_top #(
    .ClockFrequencyHz (1),
    .OnTimeMs         (1),
    .OffTimeMs        (1)
  ) u_dut_min (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .led_o (led_min)
  );

  assign leds = {led_min, led_asym, led_def};

  task automatic check(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic push_ev(input int d, input int edge_no, input logic level);
    ev_t ev;
    ev.edge_no = edge_no;
    ev.level   = level;
    case (d)
      0:       q_def.push_back(ev);
      1:       q_asym.push_back(ev);
      default: q_min.push_back(ev);
    endcase
  endtask

  // Expected transitions after reset release: rise after OffCycles edges,
  // then alternate on/off phase lengths up to last_edge.
  task automatic push_schedule(input int d, input int off_c, input int on_c, input int last_edge);
    int e = 0;
    forever begin
      e += off_c;
      if (e > last_edge) break;
      push_ev(d, e, 1'b1);
      e += on_c;
      if (e > last_edge) break;
      push_ev(d, e, 1'b0);
    end
  endtask

  task automatic pop_check(input int d, input int edge_no, input logic level);
    ev_t ev;
    int  n;
    string nm;
    case (d)
      0:       begin n = q_def.size();  nm = "def";  end
      1:       begin n = q_asym.size(); nm = "asym"; end
      default: begin n = q_min.size();  nm = "min";  end
    endcase
    checks++;
    if (n == 0) begin
      failures++;
      $display("FAIL %s_extra_edge: got led=%b at edge %0d expected no transition", nm, level, edge_no);
      return;
    end
    case (d)
      0:       ev = q_def.pop_front();
      1:       ev = q_asym.pop_front();
      default: ev = q_min.pop_front();
    endcase
    if (ev.edge_no != edge_no || ev.level !== level) begin
      failures++;
      $display("FAIL %s_transition: got led=%b at edge %0d expected led=%b at edge %0d",
               nm, level, edge_no, ev.level, ev.edge_no);
    end
  endtask

  task automatic check_drained(input string phase);
    checks++;
    if (q_def.size() != 0 || q_asym.size() != 0 || q_min.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_edges: got pending def=%0d asym=%0d min=%0d expected 0/0/0",
               phase, q_def.size(), q_asym.size(), q_min.size());
    end
  endtask

  // Monitor: count edges since reset release, sample 1 us after each edge and
  // match every observed level change against the scoreboard.
  initial begin
    int         cyc  = 0;
    logic [2:0] prev = 3'b000;
    forever begin
      @(posedge clk_i);
      if (rst_i) cyc = 0;
      else       cyc++;
      #1;
      if (rst_i) begin
        prev = leds;
      end else begin
        for (int d = 0; d < 3; d++) begin
          if (leds[d] !== prev[d]) begin
            pop_check(d, cyc, leds[d]);
            if (d == 0) begin
              if (leds[d]) $info("Led on");
              else         $info("Led off");
            end
          end
        end
        prev = leds;
      end
    end
  end

  initial begin
    // Reset held from time zero, before any clock edge.
    #1;
    check("reset_pre_edge_def", led_def, 1'b0);
    check("reset_pre_edge_asym", led_asym, 1'b0);
    check("reset_pre_edge_min", led_min, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("reset_hold", leds[0] | leds[1] | leds[2], 1'b0);
    end

    // Phase A: free run from release; default is mid-ON at edge 1150.
    push_schedule(0, 100, 100, 1150);
    push_schedule(1, 30, 10, 1150);
    push_schedule(2, 1, 1, 1150);
    rst_i = 1'b0;
    repeat (1150) @(negedge clk_i);
    check("def_on_before_reset", led_def, 1'b1);
    check("asym_on_before_reset", led_asym, 1'b1);
    check("min_off_before_reset", led_min, 1'b0);
    check_drained("run");

    // Async reset between edges must clear the LED without a clock.
    rst_i = 1'b1;
    #1;
    check("async_reset_def", led_def, 1'b0);
    check("async_reset_asym", led_asym, 1'b0);
    check("async_reset_min", led_min, 1'b0);
    repeat (3) @(negedge clk_i);
    check("reset_hold_after_abort", leds[0] | leds[1] | leds[2], 1'b0);

    // Phase B: first rise must again come OffCycles edges after release.
    push_schedule(0, 100, 100, 250);
    push_schedule(1, 30, 10, 250);
    push_schedule(2, 1, 1, 250);
    rst_i = 1'b0;
    repeat (99) @(negedge clk_i);
    check("def_still_off_edge99", led_def, 1'b0);
    repeat (1) @(negedge clk_i);
    check("def_on_edge100", led_def, 1'b1);
    repeat (150) @(negedge clk_i);
    check("def_off_edge250", led_def, 1'b0);
    check_drained("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
